// File: rtl/axil_reg_arbiter.sv
`timescale 1ns/1ps
// Two-requester arbiter in front of one AXI4-Lite master port; one single-word command in flight at a time.
// Optional build macro AXIL_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins ties) instead of round-robin.
module axil_reg_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic [1:0]            rsp0_resp,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic [1:0]            rsp1_resp,
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  output logic [2:0]            dbg_state_o,
  output logic                  dbg_last_grant_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a source holds valid and its payload stable until that edge, and requesters hold commands until reqN_ready.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e                state_q;
  logic                  last_grant_q;
  logic                  gnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
  logic                  rsp0_valid_q, rsp1_valid_q;
  logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp1_rdata_q;
  logic [1:0]            rsp0_resp_q, rsp1_resp_q;

  logic pick;
  logic accept;
  logic sel_we;
  logic aw_done, w_done;

  always_comb begin
    pick = 1'b0;
`ifdef AXIL_ARB_FIXED_PRIO_EN
    pick = !req0_valid;
`else
    if (req0_valid && req1_valid) pick = ~last_grant_q;
    else                          pick = !req0_valid;
`endif
  end

  // Grants are only offered while idle and out of reset so a held command is never lost.
  assign accept     = !ARESET && (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !pick;
  assign req1_ready = accept && pick;
  assign sel_we     = pick ? req1_we : req0_we;
  assign aw_done    = !awvalid_q || M_AXI_AWREADY;
  assign w_done     = !wvalid_q || M_AXI_WREADY;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      rready_q     <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
      rsp0_resp_q  <= 2'b00;
      rsp1_resp_q  <= 2'b00;
    end else begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            gnt_q   <= pick;
            addr_q  <= pick ? req1_addr : req0_addr;
            wdata_q <= pick ? req1_wdata : req0_wdata;
            if (sel_we) begin
              state_q   <= WR_REQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= RD_REQ;
              arvalid_q <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          // AW and W retire independently; move on once both channels are done.
          if (M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            state_q  <= WR_RESP;
            bready_q <= 1'b1;
          end
        end
        WR_RESP: begin
          if (M_AXI_BVALID) begin
            bready_q <= 1'b0;
            state_q  <= DONE;
            if (gnt_q) begin
              rsp1_valid_q <= 1'b1;
              rsp1_rdata_q <= '0;
              rsp1_resp_q  <= M_AXI_BRESP;
            end else begin
              rsp0_valid_q <= 1'b1;
              rsp0_rdata_q <= '0;
              rsp0_resp_q  <= M_AXI_BRESP;
            end
          end
        end
        RD_REQ: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (M_AXI_RVALID) begin
            rready_q <= 1'b0;
            state_q  <= DONE;
            if (gnt_q) begin
              rsp1_valid_q <= 1'b1;
              rsp1_rdata_q <= M_AXI_RDATA;
              rsp1_resp_q  <= M_AXI_RRESP;
            end else begin
              rsp0_valid_q <= 1'b1;
              rsp0_rdata_q <= M_AXI_RDATA;
              rsp0_resp_q  <= M_AXI_RRESP;
            end
          end
        end
        DONE: begin
          last_grant_q <= gnt_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign M_AXI_AWADDR     = addr_q;
  assign M_AXI_AWPROT     = 3'b000;
  assign M_AXI_AWVALID    = awvalid_q;
  assign M_AXI_WDATA      = wdata_q;
  assign M_AXI_WSTRB      = 4'hF;
  assign M_AXI_WVALID     = wvalid_q;
  assign M_AXI_BREADY     = bready_q;
  assign M_AXI_ARADDR     = addr_q;
  assign M_AXI_ARPROT     = 3'b000;
  assign M_AXI_ARVALID    = arvalid_q;
  assign M_AXI_RREADY     = rready_q;
  assign rsp0_valid       = rsp0_valid_q;
  assign rsp0_rdata       = rsp0_rdata_q;
  assign rsp0_resp        = rsp0_resp_q;
  assign rsp1_valid       = rsp1_valid_q;
  assign rsp1_rdata       = rsp1_rdata_q;
  assign rsp1_resp        = rsp1_resp_q;
  assign dbg_state_o      = state_q;
  assign dbg_last_grant_o = last_grant_q;

endmodule

// File: tb/tb_axil_reg_arbiter.sv
`timescale 1ns/1ps
// Directed bench for axil_reg_arbiter: AXI4-Lite slave model, per-requester expected queues, negedge monitor.
module tb_axil_reg_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        req0_valid, req0_ready, req0_we, rsp0_valid;
  logic [3:0]  req0_addr;
  logic [31:0] req0_wdata, rsp0_rdata;
  logic [1:0]  rsp0_resp;
  logic        req1_valid, req1_ready, req1_we, rsp1_valid;
  logic [3:0]  req1_addr;
  logic [31:0] req1_wdata, rsp1_rdata;
  logic [1:0]  rsp1_resp;
  logic [3:0]  M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;
  logic [2:0]  dbg_state;
  logic        dbg_last_grant;

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;
  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  axil_reg_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_resp(rsp0_resp),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_resp(rsp1_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .dbg_state_o(dbg_state), .dbg_last_grant_o(dbg_last_grant)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [41:0] exp0_q[$];   // {latency[7:0], resp[1:0], rdata[31:0]}
  logic [41:0] exp1_q[$];
  int          acc0_q[$];
  int          acc1_q[$];
  logic        gnt_exp_q[$];
  bit          gnt_chk_en = 1'b0;
  int          aw_hi = 0, w_hi = 0, b_hs = 0, rsp0_cnt = 0, rsp1_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- AXI4-Lite slave model ----------------
  logic [31:0] mem [4];
  int          aw_dly = 0, w_dly = 0, r_dly = 0;
  int          aw_cnt, w_cnt, r_wait;
  bit          aw_got, w_got, r_pend, aw_now, w_now;
  bit          rerr_en = 1'b0;
  logic [3:0]  aw_addr_l, wr_a;
  logic [31:0] w_data_l, wr_d;
  logic        bvalid_r, rvalid_r;
  logic [31:0] rdata_r;
  logic [1:0]  rresp_r;

  assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_dly);
  assign M_AXI_WREADY  = M_AXI_WVALID && (w_cnt >= w_dly);
  assign M_AXI_ARREADY = M_AXI_ARVALID;
  assign M_AXI_BVALID  = bvalid_r;
  assign M_AXI_BRESP   = 2'b00;
  assign M_AXI_RVALID  = rvalid_r;
  assign M_AXI_RDATA   = rdata_r;
  assign M_AXI_RRESP   = rresp_r;

  always @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      aw_cnt <= 0; w_cnt <= 0; r_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      aw_addr_l <= '0; w_data_l <= '0;
      bvalid_r <= 1'b0; rvalid_r <= 1'b0; rdata_r <= '0; rresp_r <= 2'b00;
    end else begin
      aw_now = M_AXI_AWVALID && M_AXI_AWREADY;
      w_now  = M_AXI_WVALID && M_AXI_WREADY;
      wr_a   = aw_now ? M_AXI_AWADDR : aw_addr_l;
      wr_d   = w_now ? M_AXI_WDATA : w_data_l;
      if (aw_now) begin aw_got <= 1'b1; aw_addr_l <= M_AXI_AWADDR; aw_cnt <= 0; end
      else if (M_AXI_AWVALID) aw_cnt <= aw_cnt + 1;
      if (w_now) begin w_got <= 1'b1; w_data_l <= M_AXI_WDATA; w_cnt <= 0; end
      else if (M_AXI_WVALID) w_cnt <= w_cnt + 1;
      if (M_AXI_BVALID && M_AXI_BREADY) bvalid_r <= 1'b0;
      if ((aw_now || aw_got) && (w_now || w_got)) begin
        mem[wr_a[3:2]] <= wr_d;
        bvalid_r <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) rvalid_r <= 1'b0;
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        rdata_r <= mem[M_AXI_ARADDR[3:2]];
        rresp_r <= (rerr_en && M_AXI_ARADDR == 4'h8) ? 2'b10 : 2'b00;
        if (r_dly == 0) rvalid_r <= 1'b1;
        else begin r_pend <= 1'b1; r_wait <= r_dly - 1; end
      end else if (r_pend) begin
        if (r_wait == 0) begin rvalid_r <= 1'b1; r_pend <= 1'b0; end
        else r_wait <= r_wait - 1;
      end
    end
  end

  // ---------------- monitor ----------------
  logic        prev_aw_stall = 1'b0, prev_w_stall = 1'b0, prev_ar_stall = 1'b0;
  logic [3:0]  prev_awaddr, prev_araddr;
  logic [31:0] prev_wdata;
  logic [41:0] e;

  always @(negedge ACLK) begin
    if (ARESET) begin
      acc0_q.delete();
      acc1_q.delete();
      prev_aw_stall = 1'b0;
      prev_w_stall  = 1'b0;
      prev_ar_stall = 1'b0;
    end else begin
      if (prev_aw_stall) check("aw_hold", {59'd0, M_AXI_AWVALID, M_AXI_AWADDR}, {59'd0, 1'b1, prev_awaddr});
      if (prev_w_stall)  check("w_hold", {31'd0, M_AXI_WVALID, M_AXI_WDATA}, {31'd0, 1'b1, prev_wdata});
      if (prev_ar_stall) check("ar_hold", {59'd0, M_AXI_ARVALID, M_AXI_ARADDR}, {59'd0, 1'b1, prev_araddr});
      prev_aw_stall = M_AXI_AWVALID && !M_AXI_AWREADY;
      prev_w_stall  = M_AXI_WVALID && !M_AXI_WREADY;
      prev_ar_stall = M_AXI_ARVALID && !M_AXI_ARREADY;
      prev_awaddr   = M_AXI_AWADDR;
      prev_wdata    = M_AXI_WDATA;
      prev_araddr   = M_AXI_ARADDR;
      if (M_AXI_AWVALID) aw_hi++;
      if (M_AXI_WVALID)  w_hi++;
      if (M_AXI_BVALID && M_AXI_BREADY) b_hs++;

      if (req0_ready || req1_ready) begin
        check("ready_onehot", 64'(req0_ready & req1_ready), 64'd0);
        if (req0_ready) acc0_q.push_back(cyc);
        if (req1_ready) acc1_q.push_back(cyc);
        if (gnt_chk_en) begin
          if (gnt_exp_q.size() == 0) check("grant_extra", 64'd1, 64'd0);
          else check("grant_order", 64'(req1_ready), 64'(gnt_exp_q.pop_front()));
        end
      end

      if (rsp0_valid) begin
        rsp0_cnt++;
        if (exp0_q.size() == 0) check("rsp0_unexpected", 64'd1, 64'd0);
        else begin
          e = exp0_q.pop_front();
          check("rsp0_rdata", 64'(rsp0_rdata), 64'(e[31:0]));
          check("rsp0_resp", 64'(rsp0_resp), 64'(e[33:32]));
          if (acc0_q.size() == 0) check("rsp0_no_accept", 64'd1, 64'd0);
          else check("rsp0_latency", 64'(cyc - acc0_q.pop_front()), 64'(e[41:34]));
        end
      end
      if (rsp1_valid) begin
        rsp1_cnt++;
        if (exp1_q.size() == 0) check("rsp1_unexpected", 64'd1, 64'd0);
        else begin
          e = exp1_q.pop_front();
          check("rsp1_rdata", 64'(rsp1_rdata), 64'(e[31:0]));
          check("rsp1_resp", 64'(rsp1_resp), 64'(e[33:32]));
          if (acc1_q.size() == 0) check("rsp1_no_accept", 64'd1, 64'd0);
          else check("rsp1_latency", 64'(cyc - acc1_q.pop_front()), 64'(e[41:34]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input int id, input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic [1:0] exp_resp, input logic [7:0] exp_lat,
                       input bit do_exp, output int waits);
    waits = 0;
    if (do_exp) begin
      if (id == 0) exp0_q.push_back({exp_lat, exp_resp, exp_rdata});
      else         exp1_q.push_back({exp_lat, exp_resp, exp_rdata});
    end
    if (id == 0) begin req0_we = we; req0_addr = addr; req0_wdata = wdata; req0_valid = 1'b1; end
    else         begin req1_we = we; req1_addr = addr; req1_wdata = wdata; req1_valid = 1'b1; end
    #1;
    while (!((id == 0) ? req0_ready : req1_ready) && waits < 200) begin
      @(posedge ACLK); #2;
      waits++;
    end
    if (waits >= 200) check("accept_timeout", 64'd1, 64'd0);
    @(posedge ACLK); #1;
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0) && t < 200) begin
      @(posedge ACLK); t++;
    end
    #1;
    if (t >= 200) check("drain_timeout", 64'd1, 64'd0);
    idle_cycles(2);
  endtask

  task automatic apply_reset();
    ARESET = 1'b1;
    idle_cycles(2);
    ARESET = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {56'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                           M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY | M_AXI_RREADY}, 64'd0);
    check({tag, "_rsp0"}, {30'd0, rsp0_resp, rsp0_rdata}, 64'd0);
    check({tag, "_rsp1"}, {30'd0, rsp1_resp, rsp1_rdata}, 64'd0);
    check({tag, "_axi"}, {18'd0, M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WDATA}, 64'd0);
    check({tag, "_state"}, {60'd0, dbg_state, dbg_last_grant}, 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int saved;
    logic [3:0]  a;
    logic [31:0] d;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    check_reset_outputs("reset");
    check("wstrb", 64'(M_AXI_WSTRB), 64'hF);

    // req0 writes 1..4 then reads them back, zero-wait slave
    for (int i = 0; i < 4; i++) begin
      a = 4'(i * 4);
      d = 32'(i + 1);
      issue(0, 1'b1, a, d, 32'd0, 2'b00, 8'd3, 1'b1, w);
    end
    for (int i = 0; i < 4; i++) begin
      a = 4'(i * 4);
      d = 32'(i + 1);
      issue(0, 1'b0, a, 32'd0, d, 2'b00, 8'd3, 1'b1, w);
    end
    drain();

    // error response passthrough on a read of 0x8
    rerr_en = 1'b1;
    issue(1, 1'b0, 4'h8, 32'd0, 32'd3, 2'b10, 8'd3, 1'b1, w);
    drain();
    rerr_en = 1'b0;

    // delayed AWREADY (3) and WREADY (1)
    aw_dly = 3; w_dly = 1;
    aw_hi = 0; w_hi = 0; b_hs = 0; saved = rsp0_cnt;
    issue(0, 1'b1, 4'hC, 32'hDEAD_BEEF, 32'd0, 2'b00, 8'd6, 1'b1, w);
    drain();
    check("slow_aw_cycles", 64'(aw_hi), 64'd4);
    check("slow_w_cycles", 64'(w_hi), 64'd2);
    check("slow_b_handshakes", 64'(b_hs), 64'd1);
    check("slow_rsp_count", 64'(rsp0_cnt - saved), 64'd1);
    aw_dly = 0; w_dly = 0;
    issue(1, 1'b0, 4'hC, 32'd0, 32'hDEAD_BEEF, 2'b00, 8'd3, 1'b1, w);
    drain();

    // req1 held while a req0 write is in flight
    issue(0, 1'b1, 4'h4, 32'h0000_ABCD, 32'd0, 2'b00, 8'd3, 1'b1, w);
    issue(1, 1'b0, 4'h4, 32'd0, 32'h0000_ABCD, 2'b00, 8'd3, 1'b1, w);
    check("held_req1_wait_cycles", 64'(w), 64'd3);
    drain();

    // reset while a read sits in RD_RESP
    r_dly = 6;
    saved = rsp0_cnt;
    issue(0, 1'b0, 4'h4, 32'd0, 32'd0, 2'b00, 8'd0, 1'b0, w);
    w = 0;
    while (dbg_state != 3'd4 && w < 20) begin
      @(posedge ACLK); #1;
      w++;
    end
    check("reached_rd_resp", 64'(dbg_state), 64'd4);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    check_reset_outputs("midreset");
    ARESET = 1'b0;
    r_dly = 0;
    idle_cycles(8);
    check("midreset_no_rsp", 64'(rsp0_cnt - saved), 64'd0);
    issue(1, 1'b0, 4'h0, 32'd0, 32'd0, 2'b00, 8'd3, 1'b1, w);
    drain();

    // simultaneous requesters, four commands each
    apply_reset();
    gnt_exp_q.delete();
`ifdef AXIL_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 8; i++) gnt_exp_q.push_back(i >= 4);
`else
    for (int i = 0; i < 8; i++) gnt_exp_q.push_back(i[0]);
`endif
    gnt_chk_en = 1'b1;
    fork
      begin : rr_req0
        int w0;
        issue(0, 1'b1, 4'h0, 32'h100, 32'd0,   2'b00, 8'd3, 1'b1, w0);
        issue(0, 1'b0, 4'h0, 32'd0,   32'h100, 2'b00, 8'd3, 1'b1, w0);
        issue(0, 1'b1, 4'h4, 32'h101, 32'd0,   2'b00, 8'd3, 1'b1, w0);
        issue(0, 1'b0, 4'h4, 32'd0,   32'h101, 2'b00, 8'd3, 1'b1, w0);
      end
      begin : rr_req1
        int w1;
        issue(1, 1'b1, 4'h8, 32'h200, 32'd0,   2'b00, 8'd3, 1'b1, w1);
        issue(1, 1'b0, 4'h8, 32'd0,   32'h200, 2'b00, 8'd3, 1'b1, w1);
        issue(1, 1'b1, 4'hC, 32'h201, 32'd0,   2'b00, 8'd3, 1'b1, w1);
        issue(1, 1'b0, 4'hC, 32'd0,   32'h201, 2'b00, 8'd3, 1'b1, w1);
      end
    join
    drain();
    gnt_chk_en = 1'b0;
    check("grants_consumed", 64'(gnt_exp_q.size()), 64'd0);
    check("final_last_grant", 64'(dbg_last_grant), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
